// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment scan driver:
//   - code_t / seg_t   : digit code and segment vector types
//   - CODE_*           : special digit codes (dash range, blank)
//   - GLYPH_*          : segment patterns, bit k drives segment k+1
//                        (1 top, 2 upper-right, 3 lower-right, 4 bottom,
//                         5 lower-left, 6 upper-left, 7 middle), active-high
//   - DEFAULT_NUM_DIGITS : default digit count for seg7_scan_driver
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int DEFAULT_NUM_DIGITS = 4;

    typedef logic [3:0] code_t;
    typedef logic [6:0] seg_t;

    // Codes 10..14 render a dash, 15 renders nothing.
    localparam code_t CODE_DASH_FIRST = 4'hA;
    localparam code_t CODE_DASH_LAST  = 4'hE;
    localparam code_t CODE_BLANK      = 4'hF;

    localparam seg_t GLYPH_0     = 7'b0111111;
    localparam seg_t GLYPH_1     = 7'b0000110;
    localparam seg_t GLYPH_2     = 7'b1011011;
    localparam seg_t GLYPH_3     = 7'b1001111;
    localparam seg_t GLYPH_4     = 7'b1100110;
    localparam seg_t GLYPH_5     = 7'b1101101;
    localparam seg_t GLYPH_6     = 7'b1111100;
    localparam seg_t GLYPH_7     = 7'b0000111;
    localparam seg_t GLYPH_8     = 7'b1111111;
    localparam seg_t GLYPH_9     = 7'b1100111;
    localparam seg_t GLYPH_DASH  = 7'b1000000;
    localparam seg_t GLYPH_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_dec.sv
// -----------------------------------------------------------------------------
// seg7_dec
// Combinational code-to-glyph decoder.
//   code     : 4-bit digit code (0-9 digits, 10-14 dash, 15 blank)
//   segments : 7-bit active-high segment pattern
// -----------------------------------------------------------------------------
module seg7_dec
    import seg7_pkg::*;
(
    input  code_t code,
    output seg_t  segments
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the case can infer a latch.
        segments = GLYPH_DASH;
        case (code)
            4'd0:       segments = GLYPH_0;
            4'd1:       segments = GLYPH_1;
            4'd2:       segments = GLYPH_2;
            4'd3:       segments = GLYPH_3;
            4'd4:       segments = GLYPH_4;
            4'd5:       segments = GLYPH_5;
            4'd6:       segments = GLYPH_6;
            4'd7:       segments = GLYPH_7;
            4'd8:       segments = GLYPH_8;
            4'd9:       segments = GLYPH_9;
            CODE_BLANK: segments = GLYPH_BLANK;
            default:    segments = GLYPH_DASH;   // CODE_DASH_FIRST..CODE_DASH_LAST
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-select seven-segment digits.
// New values are staged in a shadow register and only move to the display
// registers at a frame boundary, so a frame never mixes old and new digits.
//
// Parameters
//   NUM_DIGITS   : number of digits (2..8)
//   SCAN_DIV     : clk cycles per digit slot (>= 4)
//   BLANK_CYCLES : all-off time at the start of each slot (< SCAN_DIV)
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   load     : one-cycle strobe capturing value/dp_in into the shadow
//   value    : 4 bits per digit, nibble i = digit i (digit 0 least significant)
//   dp_in    : decimal-point request per digit
//   blank_lz : leading-zero blanking enable, sampled every cycle
//   segments : active-digit segment pattern (registered)
//   dp_out   : active-digit decimal point (registered)
//   digit_en : one-hot digit select, all-zero during blanking (registered)
//   pending  : a loaded value is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              segments,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    pending
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                presc;
    logic [IW-1:0]                idx;
    code_t [NUM_DIGITS-1:0]       shadow_code;
    code_t [NUM_DIGITS-1:0]       disp_code;
    logic  [NUM_DIGITS-1:0]       shadow_dp;
    logic  [NUM_DIGITS-1:0]       disp_dp;

    logic                         slot_end;
    logic                         frame_end;
    logic  [NUM_DIGITS-1:0]       lz_mask;
    logic                         upper_zero;
    code_t                        active_code;
    seg_t                         glyph;

    assign slot_end  = (presc == PRESC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Walk from the most significant digit down: a digit is a leading zero
    // while it and everything above it are zero. Digit 0 is never included.
    always_comb begin
        lz_mask    = '0;
        upper_zero = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (disp_code[i] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end

    assign active_code = lz_mask[idx] ? CODE_BLANK : disp_code[idx];

    seg7_dec u_dec (
        .code     (active_code),
        .segments (glyph)
    );

    // Scan timing: prescaler within a slot, digit index across slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state is always written with non-blocking
            // assignments so every register samples pre-edge values.
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= slot_end ? '0 : presc + PW'(1);
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    // Shadow/display double buffer. The display copy uses the pre-edge
    // shadow, so a load landing on the boundary waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these per-digit registers are few and must read as blank
            // straight out of reset, so they are reset like any control flop.
            shadow_code <= {NUM_DIGITS{CODE_BLANK}};
            disp_code   <= {NUM_DIGITS{CODE_BLANK}};
            shadow_dp   <= '0;
            disp_dp     <= '0;
            pending     <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                disp_code <= shadow_code;
                disp_dp   <= shadow_dp;
            end
            if (load) begin
                shadow_code <= value;
                shadow_dp   <= dp_in;
                pending     <= 1'b1;
            end else if (frame_end) begin
                pending     <= 1'b0;
            end
        end
    end

    // Registered pin drivers, one cycle behind presc/idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segments <= '0;
            dp_out   <= 1'b0;
            digit_en <= '0;
        end else if (presc < BLANK_END) begin
            segments <= '0;
            dp_out   <= 1'b0;
            digit_en <= '0;
        end else begin
            segments <= glyph;
            dp_out   <= disp_dp[idx];
            digit_en <= NUM_DIGITS'(1) << idx;
        end
    end

endmodule
